// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - frame buffer geometry and controller state encoding
package fb_pkg;

  localparam int FB_DEPTH  = 4096;
  localparam int FB_ADDR_W = 15;
  localparam int FB_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_SYNC    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } fb_state_t;

endpackage

// File: rtl/fb_capture_ctrl_if.sv
// rtl/fb_capture_ctrl_if.sv - camera byte stream in, frame buffer write port out
interface fb_capture_ctrl_if;

  logic                         vsync;
  logic                         href;
  logic                         pix_valid;
  logic [fb_pkg::FB_DATA_W-1:0] pix_data;
  logic                         wea;
  logic [fb_pkg::FB_ADDR_W-1:0] addra;
  logic [fb_pkg::FB_DATA_W-1:0] din;

  modport master (
    output vsync, href, pix_valid, pix_data,
    input  wea, addra, din
  );

  modport slave (
    input  vsync, href, pix_valid, pix_data,
    output wea, addra, din
  );

endinterface

// File: rtl/edge_det.sv
// rtl/edge_det.sv - rise/fall detector against a one-cycle delayed copy
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign rise = d & ~d_q;
  assign fall = ~d & d_q;

endmodule

// File: rtl/fb_capture_ctrl.sv
// rtl/fb_capture_ctrl.sv - crops/decimates the camera stream into raster writes
module fb_capture_ctrl
  import fb_pkg::*;
#(
  parameter int IMG_W         = 64,
  parameter int IMG_H         = 64,
  parameter int DECIM         = 4,
  parameter int X_START       = 0,
  parameter int Y_START       = 0,
  parameter int BYTES_PER_PIX = 2,
  parameter int KEEP_BYTE     = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               cont,
  fb_capture_ctrl_if.slave   fb,
  output logic               busy,
  output logic               frame_done,
  output logic               short_frame,
  output logic [7:0]         frame_count
);

  if (IMG_W * IMG_H > FB_DEPTH) begin : g_size_err
    $error("IMG_W*IMG_H exceeds frame buffer depth");
  end
  if (DECIM < 1) begin : g_decim_err
    $error("DECIM must be at least 1");
  end
  if (BYTES_PER_PIX < 1 || BYTES_PER_PIX > 2 || KEEP_BYTE < 0 || KEEP_BYTE >= BYTES_PER_PIX) begin : g_byte_err
    $error("BYTES_PER_PIX must be 1 or 2 with KEEP_BYTE below it");
  end

  localparam int CW = 16;
  localparam logic [CW-1:0] X0       = CW'(X_START);
  localparam logic [CW-1:0] Y0       = CW'(Y_START);
  localparam logic [CW-1:0] DEC_LAST = CW'(DECIM - 1);
  localparam logic [CW-1:0] W_LIM    = CW'(IMG_W);
  localparam logic [CW-1:0] H_LIM    = CW'(IMG_H);
  localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic PH_LAST = (BYTES_PER_PIX == 2);
  localparam logic PH_KEEP = (KEEP_BYTE == 1);

  fb_state_t state, state_d;

  logic vs_rise, vs_fall, hr_fall, hr_rise_unused;
  logic phase;
  logic [CW-1:0] x_pre, x_dec, x_cnt, y_pre, y_dec, y_cnt;
  logic [FB_ADDR_W-1:0] wr_addr;
  logic byte_ok, pix_done, x_ok, y_ok, wr_fire, last_wr;

  edge_det u_vsync_edge (.clk(clk), .rst(rst), .d(fb.vsync), .rise(vs_rise), .fall(vs_fall));
  edge_det u_href_edge  (.clk(clk), .rst(rst), .d(fb.href),  .rise(hr_rise_unused), .fall(hr_fall));

  // A byte coinciding with the href falling edge still belongs to the ending line.
  assign byte_ok  = fb.pix_valid & (fb.href | hr_fall);
  assign pix_done = (phase == PH_LAST);
  assign x_ok     = (x_pre == '0) && (x_dec == '0) && (x_cnt != W_LIM);
  assign y_ok     = (y_pre == '0) && (y_dec == '0) && (y_cnt != H_LIM);
  assign wr_fire  = (state == ST_CAPTURE) && byte_ok && (phase == PH_KEEP) && x_ok && y_ok;
  assign last_wr  = (wr_addr == LAST_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d    = state;
    frame_done = 1'b0;
    busy       = (state != ST_IDLE);
    case (state)
      ST_IDLE:    if (start) state_d = ST_ARM;
      ST_ARM:     if (vs_rise) state_d = ST_SYNC;
      ST_SYNC:    if (vs_fall) state_d = ST_CAPTURE;
      ST_CAPTURE: if ((wr_fire && last_wr) || vs_rise) state_d = ST_DONE;
      ST_DONE: begin
        frame_done = 1'b1;
        state_d    = cont ? ST_ARM : ST_IDLE;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  // Crop offset, decimation and window position are all down/up counters; no division.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || state != ST_CAPTURE) begin
      phase <= 1'b0;
      x_pre <= X0;
      x_dec <= '0;
      x_cnt <= '0;
      y_pre <= Y0;
      y_dec <= '0;
      y_cnt <= '0;
    end else if (hr_fall) begin
      phase <= 1'b0;
      x_pre <= X0;
      x_dec <= '0;
      x_cnt <= '0;
      if (y_pre != '0)      y_pre <= y_pre - 1'b1;
      else if (y_dec != '0) y_dec <= y_dec - 1'b1;
      else begin
        y_dec <= DEC_LAST;
        if (y_cnt != H_LIM) y_cnt <= y_cnt + 1'b1;
      end
    end else if (byte_ok) begin
      phase <= pix_done ? 1'b0 : ~phase;
      if (pix_done) begin
        if (x_pre != '0)      x_pre <= x_pre - 1'b1;
        else if (x_dec != '0) x_dec <= x_dec - 1'b1;
        else begin
          x_dec <= DEC_LAST;
          if (x_cnt != W_LIM) x_cnt <= x_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb.wea      <= 1'b0;
      fb.addra    <= '0;
      fb.din      <= '0;
      wr_addr     <= '0;
      frame_count <= 8'd0;
      short_frame <= 1'b0;
    end else begin
      fb.wea <= wr_fire;
      if (wr_fire) begin
        fb.addra <= wr_addr;
        fb.din   <= fb.pix_data;
        wr_addr  <= wr_addr + 1'b1;
      end else if (state != ST_CAPTURE) begin
        wr_addr <= '0;
      end
      if (wr_fire && last_wr) frame_count <= frame_count + 8'd1;
      // A vsync rise on the final write's cycle still counts as a complete frame.
      if (state == ST_IDLE && start)
        short_frame <= 1'b0;
      else if (state == ST_CAPTURE && vs_rise && !(wr_fire && last_wr))
        short_frame <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fb_capture_ctrl.sv
// tb/tb_fb_capture_ctrl.sv - directed self-checking bench for fb_capture_ctrl
module tb_fb_capture_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic cont = 1'b0;
  logic busy, frame_done, short_frame;
  logic [7:0] frame_count;

  fb_capture_ctrl_if fb ();

  fb_capture_ctrl #(
    .IMG_W(4), .IMG_H(2), .DECIM(2), .X_START(1), .Y_START(0),
    .BYTES_PER_PIX(2), .KEEP_BYTE(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .fb(fb),
    .busy(busy), .frame_done(frame_done), .short_frame(short_frame),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total = 0;

  logic [14:0] mon_addr[$];
  logic [7:0]  mon_data[$];
  int fd_cnt = 0;
  int busy_low = 0;
  logic watch_busy = 1'b0;
  logic [7:0] exp_data [4] = '{8'd3, 8'd7, 8'd11, 8'd15};

  always @(negedge clk) begin
    if (fb.wea) begin
      mon_addr.push_back(fb.addra);
      mon_data.push_back(fb.din);
    end
    if (frame_done) fd_cnt++;
    if (watch_busy && !busy) busy_low++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    cont = 1'b0;
    fb.vsync = 1'b0;
    fb.href = 1'b0;
    fb.pix_valid = 1'b0;
    fb.pix_data = 8'd0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic vsync_pulse();
    fb.vsync = 1'b1;
    repeat (3) tick();
    fb.vsync = 1'b0;
    repeat (3) tick();
  endtask

  // 10 pixels of 2 bytes, pix_data = byte index; start optionally raised on byte start_at
  task automatic send_line(input int start_at);
    fb.href = 1'b1;
    for (int i = 0; i < 20; i++) begin
      fb.pix_valid = 1'b1;
      fb.pix_data = 8'(i);
      start = (i == start_at);
      tick();
    end
    start = 1'b0;
    fb.href = 1'b0;
    fb.pix_valid = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fb.vsync = 1'b0;
    fb.href = 1'b0;
    fb.pix_valid = 1'b0;
    fb.pix_data = 8'd0;
    repeat (2) tick();
    total++; if (fb.wea !== 1'b0) $display("FAIL reset_wea: got %b want 0", fb.wea); else passed++;
    total++; if (fb.addra !== 15'd0) $display("FAIL reset_addra: got %0d want 0", fb.addra); else passed++;
    total++; if (fb.din !== 8'd0) $display("FAIL reset_din: got %0d want 0", fb.din); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b want 0", frame_done); else passed++;
    total++; if (short_frame !== 1'b0) $display("FAIL reset_short: got %b want 0", short_frame); else passed++;
    total++; if (frame_count !== 8'd0) $display("FAIL reset_count: got %0d want 0", frame_count); else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_frame();
    int bw, bf, nw;
    do_reset();
    bw = mon_addr.size();
    bf = fd_cnt;
    pulse_start();
    vsync_pulse();
    repeat (3) send_line(-1);
    nw = mon_addr.size() - bw;
    total++; if (nw !== 8) $display("FAIL full_writes: got %0d want 8", nw); else passed++;
    for (int i = 0; i < 8; i++) begin
      if (i < nw) begin
        total++; if (mon_addr[bw+i] !== 15'(i)) $display("FAIL full_addr[%0d]: got %0d want %0d", i, mon_addr[bw+i], i); else passed++;
        total++; if (mon_data[bw+i] !== exp_data[i%4]) $display("FAIL full_data[%0d]: got %0d want %0d", i, mon_data[bw+i], exp_data[i%4]); else passed++;
      end
    end
    total++; if (fd_cnt - bf !== 1) $display("FAIL full_done_pulses: got %0d want 1", fd_cnt - bf); else passed++;
    total++; if (frame_count !== 8'd1) $display("FAIL full_count: got %0d want 1", frame_count); else passed++;
    total++; if (short_frame !== 1'b0) $display("FAIL full_short: got %b want 0", short_frame); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL full_busy_after: got %b want 0", busy); else passed++;
  endtask

  task automatic test_arming();
    int bw, nw;
    do_reset();
    bw = mon_addr.size();
    vsync_pulse();
    send_line(5);
    repeat (2) send_line(-1);
    nw = mon_addr.size() - bw;
    total++; if (nw !== 0) $display("FAIL arm_no_write_midframe: got %0d want 0", nw); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL arm_busy: got %b want 1", busy); else passed++;
    fb.vsync = 1'b1;
    repeat (3) tick();
    nw = mon_addr.size() - bw;
    total++; if (nw !== 0) $display("FAIL arm_no_write_vsync: got %0d want 0", nw); else passed++;
    fb.vsync = 1'b0;
    repeat (3) tick();
    repeat (3) send_line(-1);
    nw = mon_addr.size() - bw;
    total++; if (nw !== 8) $display("FAIL arm_writes: got %0d want 8", nw); else passed++;
    if (nw >= 1) begin
      total++; if (mon_data[bw] !== 8'd3) $display("FAIL arm_first_data: got %0d want 3", mon_data[bw]); else passed++;
    end
    total++; if (frame_count !== 8'd1) $display("FAIL arm_count: got %0d want 1", frame_count); else passed++;
  endtask

  task automatic test_short_frame();
    int bw, bf, nw;
    do_reset();
    bw = mon_addr.size();
    bf = fd_cnt;
    pulse_start();
    vsync_pulse();
    send_line(-1);
    vsync_pulse();
    nw = mon_addr.size() - bw;
    total++; if (nw !== 4) $display("FAIL short_writes: got %0d want 4", nw); else passed++;
    for (int i = 0; i < 4; i++) begin
      if (i < nw) begin
        total++; if (mon_addr[bw+i] !== 15'(i)) $display("FAIL short_addr[%0d]: got %0d want %0d", i, mon_addr[bw+i], i); else passed++;
      end
    end
    total++; if (fd_cnt - bf !== 1) $display("FAIL short_done_pulses: got %0d want 1", fd_cnt - bf); else passed++;
    total++; if (short_frame !== 1'b1) $display("FAIL short_flag: got %b want 1", short_frame); else passed++;
    total++; if (frame_count !== 8'd0) $display("FAIL short_count: got %0d want 0", frame_count); else passed++;
    pulse_start();
    total++; if (short_frame !== 1'b0) $display("FAIL short_cleared: got %b want 0", short_frame); else passed++;
  endtask

  task automatic test_continuous();
    int bw, bf, bb, nw;
    do_reset();
    cont = 1'b1;
    bw = mon_addr.size();
    bf = fd_cnt;
    pulse_start();
    bb = busy_low;
    watch_busy = 1'b1;
    repeat (3) begin
      vsync_pulse();
      repeat (3) send_line(-1);
    end
    watch_busy = 1'b0;
    nw = mon_addr.size() - bw;
    total++; if (nw !== 24) $display("FAIL cont_writes: got %0d want 24", nw); else passed++;
    for (int i = 0; i < 24; i++) begin
      if (i < nw) begin
        total++; if (mon_addr[bw+i] !== 15'(i % 8)) $display("FAIL cont_addr[%0d]: got %0d want %0d", i, mon_addr[bw+i], i % 8); else passed++;
      end
    end
    total++; if (fd_cnt - bf !== 3) $display("FAIL cont_done_pulses: got %0d want 3", fd_cnt - bf); else passed++;
    total++; if (frame_count !== 8'd3) $display("FAIL cont_count: got %0d want 3", frame_count); else passed++;
    total++; if (busy_low - bb !== 0) $display("FAIL cont_busy_low_cycles: got %0d want 0", busy_low - bb); else passed++;
    cont = 1'b0;
  endtask

  task automatic test_reset_mid();
    int bw, nw;
    do_reset();
    bw = mon_addr.size();
    pulse_start();
    vsync_pulse();
    fb.href = 1'b1;
    for (int i = 0; i < 9; i++) begin
      fb.pix_valid = 1'b1;
      fb.pix_data = 8'(i);
      tick();
    end
    nw = mon_addr.size() - bw;
    total++; if (nw !== 2) $display("FAIL mid_writes_before: got %0d want 2", nw); else passed++;
    total++; if (fb.addra !== 15'd1) $display("FAIL mid_addra_before: got %0d want 1", fb.addra); else passed++;
    #2;
    rst = 1'b1;
    #1;
    total++; if (fb.wea !== 1'b0) $display("FAIL mid_rst_wea: got %b want 0", fb.wea); else passed++;
    total++; if (fb.addra !== 15'd0) $display("FAIL mid_rst_addra: got %0d want 0", fb.addra); else passed++;
    total++; if (fb.din !== 8'd0) $display("FAIL mid_rst_din: got %0d want 0", fb.din); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", busy); else passed++;
    total++; if (frame_count !== 8'd0) $display("FAIL mid_rst_count: got %0d want 0", frame_count); else passed++;
    repeat (2) tick();
    rst = 1'b0;
    bw = mon_addr.size();
    for (int i = 9; i < 20; i++) begin
      fb.pix_data = 8'(i);
      tick();
    end
    fb.href = 1'b0;
    fb.pix_valid = 1'b0;
    repeat (4) tick();
    vsync_pulse();
    repeat (3) send_line(-1);
    nw = mon_addr.size() - bw;
    total++; if (nw !== 0) $display("FAIL mid_writes_after: got %0d want 0", nw); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL mid_busy_after: got %b want 0", busy); else passed++;
  endtask

  initial begin
    fb.vsync = 1'b0;
    fb.href = 1'b0;
    fb.pix_valid = 1'b0;
    fb.pix_data = 8'd0;
    test_reset();
    test_full_frame();
    test_arming();
    test_short_frame();
    test_continuous();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
